aes256_key_sched_ctrl: RTL and testbench

Sequential AES-256 key-schedule controller for the decryption path. It accepts a 256-bit cipher key and drives one shared key-expansion step for seven iterations, one per clock. It stores all 15 round keys in a local buffer and serves them to the inverse-round datapath through an indexed read port. This block replaces the seven parallel expansion instances with a single reused step.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes256_key_sched_ctrl_step.sv | 40 ++++
 rtl/aes256_key_sched_ctrl.sv | 149 ++++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, FSM state type, rcon table and S-box for
//                the AES-256 decryption key-schedule controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int RK_NUM = 15;
    localparam int KEY_W  = 256;
    localparam int RK_W   = 128;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        EXPAND = 2'd1,
        VALID  = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit offset (255-b)*8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_key_sched_ctrl_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_key_step
//  Description : Combinational AES-256 key-expansion step: takes eight words
//                w[8i-8..8i-1] and produces w[8i..8i+7] using rcon index i.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] work_in,
    input  logic [3:0]       rcon_idx,
    output logic [KEY_W-1:0] work_out
);

    logic [31:0] w_w [8];
    logic [31:0] w_n [8];
    logic [31:0] w_t;
    logic [31:0] w_u;

    // First half uses RotWord+SubWord+rcon; second half uses SubWord only.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_w[k] = work_in[KEY_W-1-32*k -: 32];
        end
        w_t    = sub_word({w_w[7][23:0], w_w[7][31:24]}) ^ {rcon(rcon_idx), 24'h000000};
        w_n[0] = w_w[0] ^ w_t;
        for (int k = 1; k < 4; k++) begin
            w_n[k] = w_w[k] ^ w_n[k-1];
        end
        w_u    = sub_word(w_n[3]);
        w_n[4] = w_w[4] ^ w_u;
        for (int k = 5; k < 8; k++) begin
            w_n[k] = w_w[k] ^ w_n[k-1];
        end
        work_out = {w_n[0], w_n[1], w_n[2], w_n[3], w_n[4], w_n[5], w_n[6], w_n[7]};
    end

endmodule
`default_nettype wire

// File: rtl/aes256_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_key_sched_ctrl
//  Description : Sequential AES-256 key-schedule controller. One shared
//                expansion step runs seven times; the 15 round keys are kept
//                in a local buffer behind a 1-cycle indexed read port.
//  Options     : AES_KEY_ZEROIZE_EN adds key_clear (buffer/working zeroize).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic             key_clear,
`endif
    output logic             key_ready,
    output logic             keys_valid,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [RK_W-1:0]  rk_rd_data,
    output logic             rk_rd_vld,
    output logic             rk_rd_err
);

    localparam logic [3:0] c_last_idx  = 4'(RK_NUM - 1);
    localparam logic [3:0] c_last_step = 4'd7;

    state_t            r_state;
    logic [3:0]        r_step;
    logic [KEY_W-1:0]  r_work;
    logic [RK_W-1:0]   r_rk [0:RK_NUM-1];

    logic [KEY_W-1:0]  w_step_out;
    logic              w_accept;
    logic              w_clear;
    logic              w_rd_ok;
    logic [RK_W-1:0]   w_rd_word;
    logic [3:0]        w_lo_idx;
    logic [3:0]        w_hi_idx;

`ifdef AES_KEY_ZEROIZE_EN
    assign w_clear = key_clear;
`else
    assign w_clear = 1'b0;
`endif

    assign w_accept = key_load & key_ready;
    assign w_rd_ok  = keys_valid & (rk_rd_idx <= c_last_idx);
    assign w_lo_idx = {r_step[2:0], 1'b0};
    assign w_hi_idx = {r_step[2:0], 1'b1};

    aes256_key_step u_step (
        .work_in  (r_work),
        .rcon_idx (r_step),
        .work_out (w_step_out)
    );

    // Buffer read mux, guarded so index 15 never touches the array.
    always_comb begin
        w_rd_word = '0;
        if (rk_rd_idx <= c_last_idx) begin
            w_rd_word = r_rk[rk_rd_idx];
        end
    end

    // Round-key buffer and working register; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int k = 0; k < RK_NUM; k++) begin
                r_rk[k] <= '0;
            end
            r_work <= '0;
        end else if (!rst && w_accept) begin
            r_rk[0] <= key_in[KEY_W-1:RK_W];
            r_rk[1] <= key_in[RK_W-1:0];
            r_work  <= key_in;
        end else if (!rst && r_state == EXPAND) begin
            r_work         <= w_step_out;
            r_rk[w_lo_idx] <= w_step_out[KEY_W-1:RK_W];
            if (r_step != c_last_step) begin
                r_rk[w_hi_idx] <= w_step_out[RK_W-1:0];
            end
        end
    end

    // Control FSM with registered status and read-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_step     <= 4'd0;
            keys_valid <= 1'b0;
            key_ready  <= 1'b1;
            rk_rd_vld  <= 1'b0;
            rk_rd_err  <= 1'b0;
            rk_rd_data <= '0;
        end else if (w_clear) begin
            r_state    <= EMPTY;
            r_step     <= 4'd0;
            keys_valid <= 1'b0;
            key_ready  <= 1'b1;
            rk_rd_vld  <= rk_rd_en;
            rk_rd_err  <= rk_rd_en;
            rk_rd_data <= '0;
        end else begin
            rk_rd_vld <= rk_rd_en;
            rk_rd_err <= 1'b0;
            if (rk_rd_en) begin
                if (w_rd_ok) begin
                    rk_rd_data <= w_rd_word;
                end else begin
                    rk_rd_data <= '0;
                    rk_rd_err  <= 1'b1;
                end
            end
            case (r_state)
                EMPTY, VALID: begin
                    if (key_load) begin
                        r_state    <= EXPAND;
                        r_step     <= 4'd1;
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (r_step == c_last_step) begin
                        r_state    <= VALID;
                        r_step     <= 4'd0;
                        keys_valid <= 1'b1;
                        key_ready  <= 1'b1;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_step     <= 4'd0;
                    keys_valid <= 1'b0;
                    key_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes256_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes256_key_sched_ctrl
//  Description : Scoreboard bench for aes256_key_sched_ctrl. Reference model
//                derives the S-box from GF(2^8) arithmetic and expands keys
//                with the word-oriented FIPS-197 loop. Honours
//                AES_KEY_ZEROIZE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         key_clear = 1'b0;
    logic         key_ready;
    logic         keys_valid;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_rd_idx = '0;
    logic [127:0] rk_rd_data;
    logic         rk_rd_vld;
    logic         rk_rd_err;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] A3_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes256_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
`ifdef AES_KEY_ZEROIZE_EN
        .key_clear  (key_clear),
`endif
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .rk_rd_en   (rk_rd_en),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .rk_rd_vld  (rk_rd_vld),
        .rk_rd_err  (rk_rd_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_m [256];
    logic [127:0] m_rk [15];
    logic [127:0] sched_tmp [15];
    logic         m_valid = 1'b0;
    int           m_cnt   = 0;
    logic [128:0] sb [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic compute_schedule(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) sched_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive, predict, advance the model, check status.
    task automatic cyc(input logic ld, input logic [255:0] k, input logic rd,
                       input logic [3:0] idx, input logic clr);
        logic [128:0] exp;
        key_load  = ld;
        key_in    = k;
        rk_rd_en  = rd;
        rk_rd_idx = idx;
        key_clear = clr;
        if (clr)                                 exp = {1'b1, 128'h0};
        else if (m_valid && idx <= 4'd14)        exp = {1'b0, m_rk[idx]};
        else                                     exp = {1'b1, 128'h0};
        if (clr) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (ld && m_cnt == 0) begin
            compute_schedule(k);
            for (int r = 0; r < 15; r++) m_rk[r] = sched_tmp[r];
            m_cnt   = 7;
            m_valid = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end
        @(posedge clk);
        if (rd) sb.push_back(exp);
        #1;
        chk("keys_valid", 256'(keys_valid), 256'(m_valid));
        chk("key_ready", 256'(key_ready), 256'(m_cnt == 0));
        key_load  = 1'b0;
        rk_rd_en  = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1, 4'(i), 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_load = 1'b0; rk_rd_en = 1'b0; key_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_cnt   = 0;
        chk("rst_key_ready", 256'(key_ready), 256'(1));
        chk("rst_keys_valid", 256'(keys_valid), 256'(0));
        chk("rst_rd_vld_err", 256'({rk_rd_vld, rk_rd_err}), 256'(0));
        chk("rst_rd_data", 256'(rk_rd_data), 256'(0));
        rst = 1'b0;
    endtask

    // Monitor: every presented read response is matched against the queue.
    always @(negedge clk) begin
        logic [128:0] e;
        if (!rst) begin
            if (rk_rd_vld) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=vld expected=no_response");
                end else begin
                    e = sb.pop_front();
                    chk("rd_resp", 256'({rk_rd_err, rk_rd_data}), 256'(e));
                end
            end else begin
                if (sb.size() != 0) begin
                    checks++; errors++;
                    e = sb.pop_front();
                    $display("FAIL rd_missing actual=no_vld expected=%h", e);
                end
                if (rk_rd_err !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL rd_err_idle actual=%b expected=0", rk_rd_err);
                end
            end
        end
    end

    initial begin
        logic [255:0] k2;
        logic ld, rd, clr;
        build_sbox();
        do_reset();

        // FIPS-197 A.3 key, keys_valid exactly 7 cycles after accept.
        cyc(1'b1, A3_KEY, 1'b0, 4'd0, 1'b0);
        idle(7);
        cyc(1'b0, '0, 1'b1, 4'd14, 1'b0);
        chk("a3_rk14", 256'(rk_rd_data), 256'(A3_RK14));
        cyc(1'b0, '0, 1'b1, 4'd0, 1'b0);
        chk("a3_rk0", 256'(rk_rd_data), 256'(A3_KEY[255:128]));
        read_all();

        // Illegal index while valid; load with same-cycle read; read in EXPAND.
        cyc(1'b0, '0, 1'b1, 4'd15, 1'b0);
        k2 = rand_key();
        cyc(1'b1, k2, 1'b1, 4'd3, 1'b0);
        cyc(1'b0, '0, 1'b1, 4'd3, 1'b0);
        idle(2);
        // Load pulse at step 4 must be ignored.
        cyc(1'b1, rand_key(), 1'b0, 4'd0, 1'b0);
        idle(3);
        read_all();

        // Reset at step 5, then a fresh load.
        cyc(1'b1, rand_key(), 1'b0, 4'd0, 1'b0);
        idle(4);
        do_reset();
        cyc(1'b0, '0, 1'b1, 4'd0, 1'b0);
        cyc(1'b1, A3_KEY, 1'b0, 4'd0, 1'b0);
        idle(7);
        read_all();

`ifdef AES_KEY_ZEROIZE_EN
        // Clear beats load and read; reads rejected until reload completes.
        cyc(1'b1, rand_key(), 1'b1, 4'd2, 1'b1);
        cyc(1'b0, '0, 1'b1, 4'd2, 1'b0);
        k2 = rand_key();
        cyc(1'b1, k2, 1'b0, 4'd0, 1'b0);
        idle(7);
        read_all();
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ld  = ($urandom_range(0, 7) == 0);
            rd  = ($urandom_range(0, 1) == 1);
`ifdef AES_KEY_ZEROIZE_EN
            clr = ($urandom_range(0, 39) == 0);
`else
            clr = 1'b0;
`endif
            cyc(ld, rand_key(), rd, 4'($urandom_range(0, 15)), clr);
        end

        idle(2);
        chk("sb_drained", 256'(sb.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
